ks_adder_pipe: RTL and testbench

KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

---
 rtl/ks_adder_pkg.sv | 30 +++
 rtl/ks_prefix_level.sv | 21 ++
 rtl/ks_adder_pipe.sv | 184 ++++++++++++++++++
 tb/tb_ks_adder_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ks_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
// Optional feature macro used by the adder: KS_ADDER_SAT_EN (saturating result).
package ks_adder_pkg;

    // Generate/propagate pair carried through the prefix network
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of Kogge-Stone prefix levels: ceil(log2(width))
    function automatic int ks_levels(input int width);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < width) n = i + 1;
        end
        return n;
    endfunction

    // Segment (0 .. stages-1) that evaluates prefix level lvl. Segment k sits
    // between register k and register k+1; segment 0 is before the first
    // register. The last level always lands in the final segment, next to the
    // sum logic, and consecutive levels never skip a segment.
    function automatic int ks_level_stage(input int lvl, input int levels, input int stages);
        if (levels == 0) return 0;
        return ((lvl + 1) * (stages - 1)) / levels;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: each bit combines with the bit DIST below it.
module ks_prefix_level
    import ks_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  gp_t [WIDTH-1:0] gp_i,
    output gp_t [WIDTH-1:0] gp_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_comb
            assign gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[i-DIST].g);
            assign gp_o[i].p = gp_i[i].p & gp_i[i-DIST].p;
        end else begin : g_pass
            assign gp_o[i] = gp_i[i];
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract with valid/ready flow control.
// Prefix levels are spread over STAGES register boundaries; the last register
// holds the final Sum/Cout/Ovf. Define KS_ADDER_SAT_EN to add the Sat input
// that clamps overflowing results to the signed limits.
module ks_adder_pipe
    import ks_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
`ifdef KS_ADDER_SAT_EN
    input  logic             Sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int LVLS = ks_levels(WIDTH);
    // Side-band bits travelling with the data: [0] carry-in, [1] A msb,
    // [2] effective-B msb, [3] saturate request (only when enabled)
`ifdef KS_ADDER_SAT_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

    // Pipeline nodes: *_pre[j] feeds the optional register ahead of level j,
    // *_post[j] is what level j actually consumes.
    gp_t  [WIDTH-1:0] gp_pre   [0:LVLS];
    gp_t  [WIDTH-1:0] gp_post  [0:LVLS-1];
    logic [WIDTH-1:0] p0_pre   [0:LVLS];
    logic [WIDTH-1:0] p0_post  [0:LVLS-1];
    logic [SW-1:0]    side_pre [0:LVLS];
    logic [SW-1:0]    side_post[0:LVLS-1];

    logic [STAGES:1]  vld_pipe;
    logic [STAGES:1]  rdy;
    logic [STAGES:0]  vchain;
    logic             rdy_en;
    logic             acc;
    logic [WIDTH-1:0] b_eff;

    assign acc    = in_valid & in_ready;
    assign vchain = {vld_pipe, acc};

    // Operand conditioning: subtraction is A + ~B + ~Cin
    assign b_eff       = Sub ? ~B : B;
    assign p0_pre[0]   = A ^ b_eff;
    assign side_pre[0][0] = Sub ? ~Cin : Cin;
    assign side_pre[0][1] = A[WIDTH-1];
    assign side_pre[0][2] = b_eff[WIDTH-1];
`ifdef KS_ADDER_SAT_EN
    assign side_pre[0][3] = Sat;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_gp0
        assign gp_pre[0][i].g = A[i] & b_eff[i];
        assign gp_pre[0][i].p = A[i] ^ b_eff[i];
    end

    for (genvar j = 0; j < LVLS; j++) begin : g_lvl
        localparam int SEG  = ks_level_stage(j, LVLS, STAGES);
        localparam int PREV = (j == 0) ? 0 : ks_level_stage(j - 1, LVLS, STAGES);

        if (SEG > PREV) begin : g_reg
            gp_t  [WIDTH-1:0] gp_q;
            logic [WIDTH-1:0] p0_q;
            logic [SW-1:0]    side_q;

            // Stage register ahead of this level; data loads whenever the stage can accept
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gp_q   <= '0;
                    p0_q   <= '0;
                    side_q <= '0;
                end else if (rdy[SEG]) begin
                    gp_q   <= gp_pre[j];
                    p0_q   <= p0_pre[j];
                    side_q <= side_pre[j];
                end
            end

            assign gp_post[j]   = gp_q;
            assign p0_post[j]   = p0_q;
            assign side_post[j] = side_q;
        end else begin : g_thru
            assign gp_post[j]   = gp_pre[j];
            assign p0_post[j]   = p0_pre[j];
            assign side_post[j] = side_pre[j];
        end

        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << j)
        ) u_lvl (
            .gp_i (gp_post[j]),
            .gp_o (gp_pre[j+1])
        );

        assign p0_pre[j+1]   = p0_post[j];
        assign side_pre[j+1] = side_post[j];
    end

    // Final carries: group (G,P) over [i:0] combined with the carry-in
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] sum_f;
    logic             ovf_w;
    logic             a_msb;
    logic             b_msb;

    assign carry[0] = side_pre[LVLS][0];
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry[i+1] = gp_pre[LVLS][i].g | (gp_pre[LVLS][i].p & side_pre[LVLS][0]);
    end

    assign a_msb = side_pre[LVLS][1];
    assign b_msb = side_pre[LVLS][2];
    assign sum_w = p0_pre[LVLS] ^ carry[WIDTH-1:0];
    assign ovf_w = (a_msb == b_msb) && (sum_w[WIDTH-1] != a_msb);

`ifdef KS_ADDER_SAT_EN
    // Clamp toward the sign of the operands when overflow occurs
    assign sum_f = (side_pre[LVLS][3] && ovf_w)
                 ? (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                 : sum_w;
`else
    assign sum_f = sum_w;
`endif

    // Output register; held while the result waits for out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
            Ovf  <= 1'b0;
        end else if (rdy[STAGES]) begin
            Sum  <= sum_f;
            Cout <= carry[WIDTH];
            Ovf  <= ovf_w;
        end
    end

    // Stage k can take new contents when empty or when its successor takes its contents
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = ~vld_pipe[STAGES] | out_ready;
        for (int k = STAGES - 1; k >= 1; k--) begin
            rdy[k] = ~vld_pipe[k] | rdy[k+1];
        end
    end

    // Valid bits advance in lockstep with their stage data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (rdy[k]) vld_pipe[k] <= vchain[k-1];
            end
        end
    end

    // Keeps in_ready low during reset and until the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    assign in_ready  = rdy_en & rdy[1];
    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed and random checks of ks_adder_pipe (WIDTH=32, STAGES=3).
module tb_ks_adder_pipe;

    localparam int W = 32;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         Sub = 1'b0;
    logic         sat_s = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    logic [W+1:0] q[$];

    ks_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
`ifdef KS_ADDER_SAT_EN
        .Sat       (sat_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 33-bit reference: returns {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic ci, su, sa);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   r;
        logic [W-1:0] s;
        logic         ov;
        be = su ? ~b : b;
        ce = su ? ~ci : ci;
        r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
        s  = r[W-1:0];
        ov = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
`ifdef KS_ADDER_SAT_EN
        if (sa && ov) s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (sa) s = s;
`endif
        return {ov, r[W], s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check in_ready and any result handshake, advance
    task automatic step(input logic iv, input logic [W-1:0] a, b,
                        input logic ci, su, sa, ordy, output logic took);
        logic [W+1:0] e;
        in_valid = iv; A = a; B = b; Cin = ci; Sub = su; sat_s = sa; out_ready = ordy;
        #1;
        chk("in_ready", {63'b0, in_ready}, (q.size() == S && !ordy) ? 64'd0 : 64'd1);
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("result", {30'b0, Ovf, Cout, Sum}, {30'b0, e});
                delivered++;
            end
        end
        took = iv && in_ready;
        if (took) q.push_back(model(a, b, ci, su, sa));
        @(negedge clk);
    endtask

    // Isolated beat: checks latency and hand-computed result
    task automatic single(input string tag, input logic [W-1:0] a, b, input logic ci, su, sa,
                          input logic [W-1:0] es, input logic ec, eo);
        in_valid = 1'b1; A = a; B = b; Cin = ci; Sub = su; sat_s = sa; out_ready = 1'b1;
        #1 chk({tag, " accept"}, {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k < S; k++) begin
            #1 chk({tag, " early out_valid"}, {63'b0, out_valid}, 64'd0);
            @(negedge clk);
        end
        #1;
        chk({tag, " out_valid"}, {63'b0, out_valid}, 64'd1);
        chk({tag, " Sum"}, {32'b0, Sum}, {32'b0, es});
        chk({tag, " Cout"}, {63'b0, Cout}, {63'b0, ec});
        chk({tag, " Ovf"}, {63'b0, Ovf}, {63'b0, eo});
        @(negedge clk);
        #1 chk({tag, " drained"}, {63'b0, out_valid}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic took;
        int   sent;
        int   cyc;
        int   rnd_del;

        // Reset state
        #2;
        chk("rst out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst Sum", {32'b0, Sum}, 64'd0);
        chk("rst Cout/Ovf", {62'b0, Cout, Ovf}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1 chk("in_ready before first edge", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        #1 chk("in_ready after first edge", {63'b0, in_ready}, 64'd1);
        @(negedge clk);

        // Directed vectors
        single("wrap add", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        single("pos ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single("sub borrow", 32'h5, 32'h7, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single("add cin", 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0);
        single("sub bin", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single("sub ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        single("neg ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef KS_ADDER_SAT_EN
        single("sat pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        single("sat neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`endif

        // Back-to-back beats with out_ready low for cycles 4-8
        sent = 0;
        delivered = 0;
        cyc = 0;
        while ((delivered < 10) && (cyc < 60)) begin
            step(sent < 10, 32'h1000_0001 * sent, 32'h3 * sent + 32'hFFFF_FFF0, sent[0], sent[1], 1'b0,
                 !(cyc >= 4 && cyc <= 8), took);
            if (took) sent++;
            cyc++;
        end
        chk("bp delivered", delivered, 10);
        chk("bp queue empty", q.size(), 0);

        // Reset with beats in flight
        step(1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, took);
        step(1'b1, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, took);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, took);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, took);
        #1 chk("pre-reset out_valid", {63'b0, out_valid}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-reset out_valid", {63'b0, out_valid}, 64'd0);
        chk("mid-reset Sum", {32'b0, Sum}, 64'd0);
        chk("mid-reset in_ready", {63'b0, in_ready}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            #1 chk("post-reset stale", {63'b0, out_valid}, 64'd0);
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, took);
        end

        // Random beats with random backpressure
        sent = 0;
        delivered = 0;
        cyc = 0;
        while ((sent < 10000) && (cyc < 40000)) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, took);
            if (took) sent++;
            cyc++;
        end
        cyc = 0;
        while ((q.size() != 0) && (cyc < 100)) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, took);
            cyc++;
        end
        rnd_del = delivered;
        chk("random accepted", sent, 10000);
        chk("random delivered", rnd_del, 10000);
        chk("random queue empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
